// File: rtl/st_channel_adapter_buffered.sv
// Avalon-ST channel adapter: remaps in_channel into a narrower destination
// range, filters out-of-range traffic per packet or per beat, and registers
// the output through an output register backed by a one-entry skid buffer.
module st_channel_adapter_buffered #(
  parameter int DATA_W      = 8,
  parameter int IN_CHAN_W   = 8,
  parameter int OUT_CHAN_W  = 1,
  parameter int CHAN_BASE   = 0,
  parameter int MAX_CHANNEL = 0,
  parameter int PKT_DROP    = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [IN_CHAN_W-1:0]  in_channel,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [OUT_CHAN_W-1:0] out_channel,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [CNT_W-1:0]      drop_count,
  output logic                  drop_pulse,
  output logic                  proto_err
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  localparam int BW = DATA_W + OUT_CHAN_W + 2;

  // Range bounds carry one extra bit so CHAN_BASE+MAX_CHANNEL cannot wrap.
  localparam logic [IN_CHAN_W:0] CH_LO = (IN_CHAN_W+1)'(CHAN_BASE);
  localparam logic [IN_CHAN_W:0] CH_HI = (IN_CHAN_W+1)'(CHAN_BASE + MAX_CHANNEL);

  state_t                state, state_next;
  logic [OUT_CHAN_W-1:0] chan_q, chan_next;
  logic [OUT_CHAN_W-1:0] chan_map, fwd_chan;
  logic                  accept, chan_ok;
  logic                  fwd, drop, perr_set;

  logic [BW-1:0]         beat_in;
  logic [BW-1:0]         out_beat, out_beat_next;
  logic [BW-1:0]         skid_beat, skid_beat_next;
  logic                  out_valid_next, skid_full, skid_full_next;
  logic                  out_stall;

  assign accept   = in_valid & in_ready;
  assign chan_ok  = ({1'b0, in_channel} >= CH_LO) && ({1'b0, in_channel} <= CH_HI);
  assign chan_map = OUT_CHAN_W'(in_channel - IN_CHAN_W'(CHAN_BASE));
  assign beat_in  = {in_data, fwd_chan, in_startofpacket, in_endofpacket};
  assign out_stall = out_valid & ~out_ready;

  assign {out_data, out_channel, out_startofpacket, out_endofpacket} = out_beat;

  // Packet filter: decide whether an accepted beat is forwarded or dropped.
  always_comb begin
    state_next = state;
    chan_next  = chan_q;
    fwd_chan   = chan_map;
    fwd        = 1'b0;
    drop       = 1'b0;
    perr_set   = 1'b0;
    if (accept) begin
      if (PKT_DROP == 0) begin
        if (chan_ok) fwd = 1'b1;
        else         drop = 1'b1;
      end else if (in_startofpacket) begin
        // An SOP restarts framing from any state; only a non-IDLE SOP is an error.
        if (state != IDLE) perr_set = 1'b1;
        if (chan_ok) begin
          fwd        = 1'b1;
          chan_next  = chan_map;
          state_next = in_endofpacket ? IDLE : PASS;
        end else begin
          drop       = 1'b1;
          state_next = in_endofpacket ? IDLE : DROP;
        end
      end else begin
        case (state)
          PASS: begin
            fwd      = 1'b1;
            fwd_chan = chan_q;
            if (in_endofpacket) state_next = IDLE;
          end
          DROP: begin
            if (in_endofpacket) state_next = IDLE;
          end
          default: perr_set = 1'b1;
        endcase
      end
    end
  end

  // Output/skid steering: skid refills the output first whenever it drains.
  always_comb begin
    out_valid_next = out_valid;
    out_beat_next  = out_beat;
    skid_full_next = skid_full;
    skid_beat_next = skid_beat;
    if (!out_stall) begin
      if (skid_full) begin
        out_valid_next = 1'b1;
        out_beat_next  = skid_beat;
        skid_full_next = 1'b0;
      end else if (fwd) begin
        out_valid_next = 1'b1;
        out_beat_next  = beat_in;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (fwd) begin
      skid_full_next = 1'b1;
      skid_beat_next = beat_in;
    end
  end

  // State, buffer, ready and drop/error bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      chan_q     <= '0;
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_full  <= 1'b0;
      skid_beat  <= '0;
      in_ready   <= 1'b1;
      drop_count <= '0;
      drop_pulse <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_next;
      chan_q     <= chan_next;
      out_valid  <= out_valid_next;
      out_beat   <= out_beat_next;
      skid_full  <= skid_full_next;
      skid_beat  <= skid_beat_next;
      in_ready   <= ~skid_full_next;
      drop_pulse <= drop;
      if (drop && (drop_count != '1)) drop_count <= drop_count + CNT_W'(1);
      if (perr_set) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_st_channel_adapter_buffered.sv
// Directed bench for st_channel_adapter_buffered: three instances share the
// stimulus (default config, remapping beat-drop config, 2-bit counter config).
module tb_st_channel_adapter_buffered;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_sop, in_eop, out_ready;
  logic [7:0] in_data, in_channel;

  logic       a_in_ready, a_out_valid, a_sop, a_eop, a_pulse, a_perr;
  logic [7:0] a_data;
  logic [0:0] a_chan;
  logic [15:0] a_cnt;

  logic       b_in_ready, b_out_valid, b_sop, b_eop, b_pulse, b_perr;
  logic [7:0] b_data;
  logic [1:0] b_chan;
  logic [15:0] b_cnt;

  logic       c_in_ready, c_out_valid, c_sop, c_eop, c_pulse, c_perr;
  logic [7:0] c_data;
  logic [0:0] c_chan;
  logic [1:0] c_cnt;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // T4 table: stimulus before each edge, expected state after it.
  logic       t4_v   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] t4_d   [7] = '{8'h50, 8'h51, 8'h52, 8'h52, 8'h52, 8'h53, 8'h00};
  logic       t4_r   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       t4_ir  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       t4_ov  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] t4_od  [7] = '{8'h50, 8'h50, 8'h50, 8'h51, 8'h52, 8'h53, 8'h00};

  always #5 clk = ~clk;

  st_channel_adapter_buffered u_a (
    .clk(clk), .reset_n(reset_n), .in_ready(a_in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_channel(in_channel), .in_startofpacket(in_sop),
    .in_endofpacket(in_eop), .out_ready(out_ready), .out_valid(a_out_valid),
    .out_data(a_data), .out_channel(a_chan), .out_startofpacket(a_sop),
    .out_endofpacket(a_eop), .drop_count(a_cnt), .drop_pulse(a_pulse), .proto_err(a_perr)
  );

  st_channel_adapter_buffered #(
    .OUT_CHAN_W(2), .CHAN_BASE(4), .MAX_CHANNEL(3), .PKT_DROP(0)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .in_ready(b_in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_channel(in_channel), .in_startofpacket(in_sop),
    .in_endofpacket(in_eop), .out_ready(out_ready), .out_valid(b_out_valid),
    .out_data(b_data), .out_channel(b_chan), .out_startofpacket(b_sop),
    .out_endofpacket(b_eop), .drop_count(b_cnt), .drop_pulse(b_pulse), .proto_err(b_perr)
  );

  st_channel_adapter_buffered #(.CNT_W(2)) u_c (
    .clk(clk), .reset_n(reset_n), .in_ready(c_in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_channel(in_channel), .in_startofpacket(in_sop),
    .in_endofpacket(in_eop), .out_ready(out_ready), .out_valid(c_out_valid),
    .out_data(c_data), .out_channel(c_chan), .out_startofpacket(c_sop),
    .out_endofpacket(c_eop), .drop_count(c_cnt), .drop_pulse(c_pulse), .proto_err(c_perr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic [7:0] ch, input logic s, input logic e);
    in_valid = 1'b1; in_data = d; in_channel = ch; in_sop = s; in_eop = e;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_channel = '0;
    in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    // T0: reset values
    do_reset();
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_data, 0);
    chk("rst_sop_eop", {a_sop, a_eop}, 0);
    chk("rst_drop_count", a_cnt, 0);
    chk("rst_drop_pulse", a_pulse, 0);
    chk("rst_proto_err", a_perr, 0);

    // T1: ch0 4-beat packet, 1-cycle latency
    beat(8'h11, 8'd0, 1'b1, 1'b0);
    chk("t1_b0", {a_out_valid, a_data, a_chan, a_sop, a_eop}, {1'b1, 8'h11, 1'b0, 1'b1, 1'b0});
    beat(8'h12, 8'd0, 1'b0, 1'b0);
    chk("t1_b1", {a_out_valid, a_data, a_chan, a_sop, a_eop}, {1'b1, 8'h12, 1'b0, 1'b0, 1'b0});
    beat(8'h13, 8'd0, 1'b0, 1'b0);
    chk("t1_b2", {a_out_valid, a_data, a_chan, a_sop, a_eop}, {1'b1, 8'h13, 1'b0, 1'b0, 1'b0});
    beat(8'h14, 8'd0, 1'b0, 1'b1);
    chk("t1_b3", {a_out_valid, a_data, a_chan, a_sop, a_eop}, {1'b1, 8'h14, 1'b0, 1'b0, 1'b1});
    chk("t1_in_ready", a_in_ready, 1);
    idle();
    chk("t1_drain", a_out_valid, 0);

    // T2: ch3 packet dropped whole, ch0 packet forwarded
    do_reset();
    beat(8'h21, 8'd3, 1'b1, 1'b0);
    chk("t2_drop_sop", {a_out_valid, a_pulse, a_cnt}, {1'b0, 1'b1, 16'd1});
    beat(8'h22, 8'd3, 1'b0, 1'b0);
    chk("t2_drop_mid", {a_out_valid, a_pulse, a_cnt}, {1'b0, 1'b0, 16'd1});
    beat(8'h23, 8'd3, 1'b0, 1'b1);
    chk("t2_drop_eop", {a_out_valid, a_pulse, a_cnt}, {1'b0, 1'b0, 16'd1});
    beat(8'h31, 8'd0, 1'b1, 1'b0);
    chk("t2_pass_sop", {a_out_valid, a_data, a_sop, a_eop}, {1'b1, 8'h31, 1'b1, 1'b0});
    beat(8'h32, 8'd0, 1'b0, 1'b1);
    chk("t2_pass_eop", {a_out_valid, a_data, a_sop, a_eop}, {1'b1, 8'h32, 1'b0, 1'b1});
    chk("t2_count", {a_pulse, a_cnt}, {1'b0, 16'd1});
    chk("t2_proto_err", a_perr, 0);

    // T3: base 4, range 4..7, per-beat drop
    do_reset();
    beat(8'h41, 8'd3, 1'b1, 1'b1);
    chk("t3_ch3", {b_out_valid, b_pulse}, {1'b1 ^ 1'b1, 1'b1});
    beat(8'h42, 8'd4, 1'b1, 1'b1);
    chk("t3_ch4", {b_out_valid, b_data, b_chan, b_pulse}, {1'b1, 8'h42, 2'd0, 1'b0});
    beat(8'h43, 8'd7, 1'b1, 1'b1);
    chk("t3_ch7", {b_out_valid, b_data, b_chan}, {1'b1, 8'h43, 2'd3});
    beat(8'h44, 8'd8, 1'b1, 1'b1);
    chk("t3_ch8", {b_out_valid, b_pulse}, {1'b0, 1'b1});
    chk("t3_count", b_cnt, 2);

    // T4: backpressure pattern 1,0,0,1,1 through the skid buffer
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_valid = t4_v[i]; in_data = t4_d[i]; in_channel = 8'd0;
      in_sop = 1'b1; in_eop = 1'b1; out_ready = t4_r[i];
      @(posedge clk); #1;
      chk($sformatf("t4_in_ready_%0d", i), a_in_ready, t4_ir[i]);
      chk($sformatf("t4_out_valid_%0d", i), a_out_valid, t4_ov[i]);
      if (t4_ov[i]) chk($sformatf("t4_out_data_%0d", i), a_data, t4_od[i]);
    end

    // T5: nested SOP and stray beat set sticky proto_err
    do_reset();
    beat(8'h61, 8'd0, 1'b1, 1'b0);
    chk("t5_first", {a_out_valid, a_data, a_sop, a_perr}, {1'b1, 8'h61, 1'b1, 1'b0});
    beat(8'h62, 8'd0, 1'b1, 1'b0);
    chk("t5_resop", {a_out_valid, a_data, a_sop, a_perr}, {1'b1, 8'h62, 1'b1, 1'b1});
    beat(8'h63, 8'd5, 1'b0, 1'b1);
    chk("t5_latched_ch", {a_out_valid, a_data, a_chan, a_eop}, {1'b1, 8'h63, 1'b0, 1'b1});
    beat(8'h64, 8'd0, 1'b0, 1'b0);
    chk("t5_stray", {a_out_valid, a_perr}, {1'b0, 1'b1});
    idle();
    idle();
    chk("t5_sticky", a_perr, 1);

    // T6: 2-bit counter saturation, then reset mid-packet
    do_reset();
    beat(8'h70, 8'd1, 1'b1, 1'b1);
    chk("t6_drop1", {c_out_valid, c_pulse, c_cnt}, {1'b0, 1'b1, 2'd1});
    beat(8'h70, 8'd1, 1'b1, 1'b1);
    chk("t6_drop2", c_cnt, 2);
    beat(8'h70, 8'd1, 1'b1, 1'b1);
    chk("t6_drop3", c_cnt, 3);
    beat(8'h70, 8'd1, 1'b1, 1'b1);
    chk("t6_drop4", {c_pulse, c_cnt}, {1'b1, 2'd3});
    beat(8'h70, 8'd1, 1'b1, 1'b1);
    chk("t6_drop5", {c_pulse, c_cnt}, {1'b1, 2'd3});
    out_ready = 1'b0;
    beat(8'h71, 8'd0, 1'b1, 1'b0);
    chk("t6_mid_out", {c_out_valid, c_data, c_in_ready}, {1'b1, 8'h71, 1'b1});
    beat(8'h72, 8'd0, 1'b0, 1'b0);
    chk("t6_skid_full", {c_out_valid, c_data, c_in_ready}, {1'b1, 8'h71, 1'b0});
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_outs", {c_out_valid, c_data, c_chan, c_sop, c_eop}, 0);
    chk("t6_rst_flags", {c_in_ready, c_cnt, c_pulse, c_perr}, {1'b1, 2'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    beat(8'h73, 8'd0, 1'b0, 1'b1);
    chk("t6_post_idle", {c_out_valid, c_perr}, {1'b0, 1'b1});
    idle();
    chk("t6_no_partial", c_out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
